spi_flash_responder: RTL and testbench
======================================

# spi_flash_responder

SPI-mode-0 responder that emulates a serial NOR flash toward the CPU's flash-fetch controller. It decodes the opcode/address stream on the flash pins and serves read data MSB-first. Sequential reads continue indefinitely while CS stays low, matching the controller's "keep CS low, clock 8 more bits" fetch path. It sits on the far side of the ROM pins, in test harnesses and in companion designs that host program memory. Byte storage is external, behind a fixed-latency read port.

## Interface

- `JEDEC_ID`, 24'hEF4016, three bytes returned MSB-first by opcode 0x9F.
- `STATUS`, 8'h00, byte returned repeatedly by opcode 0x05.
- `clk`  in  1  system clock; frequency must be ≥ 8× SCLK.
- `rst_n`  in  1  reset, synchronous, active-low.
- `spi_cs_n`  in  1  chip select from controller; asynchronous to `clk`.
- `spi_sclk`  in  1  serial clock from controller; asynchronous.
- `spi_mosi`  in  1  controller data out; asynchronous.
- `spi_miso`  out  1  responder data; reset 0.
- `spi_miso_oe`  out  1  MISO drive enable; reset 0.
- `mem_req`  out  1  one-cycle read strobe; reset 0.
- `mem_addr`  out  24  byte address, valid with `mem_req`; reset 0.
- `mem_rdata`  in  8  read data, valid exactly 1 clk after `mem_req`.
- `busy`  out  1  transaction in progress (state ≠ IDLE); reset 0.
- `cmd_err`  out  1  one-cycle pulse on an unsupported opcode; reset 0.

## Operation

- **Synchronizer**
  - Each pin passes through 2 flops plus a history flop.
  - Edge detect yields `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`.
  - Synchronized CS resets to 0 (asserted). A CS held low across reset release therefore produces no `cs_fall`.
- **Bit transfer**
  - MOSI is sampled on `sclk_rise`, MSB first, into an 8-bit shift register with a 3-bit counter.
  - MISO changes only on `sclk_fall`, or on the byte-load rule below.
- **States:** IDLE, CMD, ADDR, DUMMY, DATA, ID, STAT, IGNORE.
  - IDLE → CMD on `cs_fall`.
  - CMD, after 8 bits:
    - 0x03 → ADDR, then DATA.
    - 0x0B → ADDR, then DUMMY (8 bits, ignored), then DATA.
    - 0x9F → ID.
    - 0x05 → STAT.
    - Any other opcode → IGNORE, with `cmd_err` pulsed in the decode cycle.
  - ADDR collects 24 bits into `addr_q`.
  - `cs_rise` in any state → IDLE. This clears `spi_miso_oe`, `spi_miso`, counters and any pending fetch.
- **DATA**
  - Entry: `mem_req` is issued with `mem_addr = addr_q` in the cycle after the last address (or dummy) bit's `sclk_rise`.
  - The next clk captures `mem_rdata` into the output shift register. `spi_miso` is set to bit 7 immediately; `spi_miso_oe` goes to 1.
  - Each `sclk_fall` shifts the next bit out.
  - On the `sclk_rise` of bit 0 of each byte:
    - `addr_q` increments modulo 2^24 (0xFFFFFF → 0x000000).
    - `mem_req` issues for the new address.
    - The fetched byte loads on the following `sclk_fall`, with bit 7 driven at that edge.
- **ID**
  - Serves `JEDEC_ID[23:16]`, then `[15:8]`, then `[7:0]`, then 0x00 until `cs_rise`.
  - No `mem_req`.
- **STAT:** serves `STATUS` repeatedly; no `mem_req`.
- **IGNORE:** `spi_miso_oe` stays 0; waits for `cs_rise`.
- `spi_miso_oe` is 1 only in DATA, ID and STAT after the first byte is loaded.

## Timing

- Pin-to-detect latency: 3 clk (2 sync + edge compare).
- SCLK high and low phases must each be ≥ 4 clk. This guarantees that `mem_req` (rise + 1), data capture (rise + 2) and the shift load complete before `sclk_fall` is detected.
- First data bit is valid ≤ 3 clk after the falling SCLK edge that follows the last address/dummy bit.
- `mem_req` is exactly 1 clk wide, at most one per byte.
- Simultaneous `cs_rise` and `sclk_rise`: `cs_rise` wins and the bit is discarded.
- `rst_n` low mid-transaction:
  - All outputs take their reset values on the next clk.
  - The state goes to IDLE.
  - No response until CS goes high and then low again.

## Structure

- Package `spi_flash_pkg`: opcode constants (`OP_READ` = 8'h03, `OP_FAST_READ` = 8'h0B, `OP_RDID` = 8'h9F, `OP_RDSR` = 8'h05) and the state enum.
- One sub-module, `spi_pin_sync`: 2-flop synchronizer plus edge detector, instantiated for CS (reset value 0), SCLK (reset value 0) and MOSI (no edge outputs).
- Decode, FSM, address counter and shifters live in the top module.

## Test plan

- **READ.** Stimulus: CS low, 0x03, address 0x000010, 16 more SCLKs; memory model returns `addr[7:0] ^ 8'h5A`. Required: `mem_addr` = 0x000010 then 0x000011; MISO bytes 0x4A, 0x4B; exactly 2 `mem_req`.
- **Wrap.** Stimulus: 0x03, address 0xFFFFFF, 2 bytes. Required: `mem_addr` = 0xFFFFFF then 0x000000.
- **Fast read.** Stimulus: 0x0B, address 0x000100, dummy 0xFF, 1 byte. Required: `mem_req` only after the dummy byte; MISO = model(0x100).
- **JEDEC ID.** Stimulus: 0x9F, 4 bytes. Required: 0xEF, 0x40, 0x16, 0x00; `mem_req` never asserted.
- **Bad opcode / abort.**
  - Stimulus: 0xAB, 8 more clocks. Required: `cmd_err` one pulse; `spi_miso_oe` stays 0.
  - Stimulus: 0x03 with CS raised after 12 address bits. Required: state returns to IDLE, no `mem_req`; a following READ of 0x000020 returns the correct byte.
- **Reset mid-read.** Stimulus: `rst_n` low for 2 clk during the DATA phase with CS held low. Required: `spi_miso_oe` = 0, `busy` = 0; continued SCLK ignored; after CS high-then-low, a READ works.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM state encoding and ID byte selection for the flash responder
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_RDID      = 8'h9F;
    localparam logic [7:0] OP_RDSR      = 8'h05;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        ID,
        STAT,
        IGNORE
    } state_t;

    // Byte idx of the JEDEC ID, MSB first; anything past the third byte reads as zero
    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        return idx == 2'd0 ? id[23:16] : idx == 2'd1 ? id[15:8] : idx == 2'd2 ? id[7:0] : 8'h00;
    endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: flash pins toward the fetch controller plus the external byte-read port
interface spi_flash_responder_if;

    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata;

    modport slave (
        input  spi_cs_n, spi_sclk, spi_mosi, mem_rdata,
        output spi_miso, spi_miso_oe, mem_req, mem_addr
    );

    modport master (
        output spi_cs_n, spi_sclk, spi_mosi, mem_rdata,
        input  spi_miso, spi_miso_oe, mem_req, mem_addr
    );

endinterface

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: two-flop synchronizer for an asynchronous pin plus a history flop for edge detection
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, h_q;

    // Metastability chain; the third flop remembers the previous synchronized level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            h_q  <= RST_VAL;
        end else begin
            s1_q <= pin;
            s2_q <= s1_q;
            h_q  <= s2_q;
        end
    end

    assign sync = s2_q;
    assign rise = s2_q & ~h_q;
    assign fall = ~s2_q & h_q;

endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 serial NOR flash emulator serving READ, FAST_READ, RDID and RDSR
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter logic [7:0]  STATUS   = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_flash_responder_if.slave  bus,
    output logic                  busy,
    output logic                  cmd_err
);

    logic cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_s;
    logic unused_cs, unused_sclk, unused_mosi_rise, unused_mosi_fall;

    // CS rise means deselect, CS fall means select; synchronized CS starts asserted so a
    // CS held low through reset release never looks like a new selection
    spi_pin_sync #(.RST_VAL(1'b0)) u_cs (
        .clk(clk), .rst_n(rst_n), .pin(bus.spi_cs_n),
        .sync(unused_cs), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_sync #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .pin(bus.spi_sclk),
        .sync(unused_sclk), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .pin(bus.spi_mosi),
        .sync(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_q, byte_d;
    logic [23:0] addr_q, addr_d;
    logic        fast_q, fast_d;
    logic [7:0]  sh_in_q, sh_in_d;
    logic [7:0]  sh_out_q, sh_out_d;
    logic [7:0]  nxt_q, nxt_d;
    logic        load_pend_q, load_pend_d;
    logic        cap_q, cap_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        mem_req_q, mem_req_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic        cmd_err_q, cmd_err_d;

    logic [7:0] rx;
    logic       last;

    assign rx   = {sh_in_q[6:0], mosi_s};
    assign last = bit_cnt_q == 3'd7;

    // Next-state logic: deselect dominates, then read-data capture, MISO shifting on SCLK fall,
    // and bit reception / opcode decode on SCLK rise
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_d      = byte_q;
        addr_d      = addr_q;
        fast_d      = fast_q;
        sh_in_d     = sh_in_q;
        sh_out_d    = sh_out_q;
        nxt_d       = nxt_q;
        load_pend_d = load_pend_q;
        cap_d       = mem_req_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        mem_req_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        cmd_err_d   = 1'b0;
        if (cs_rise) begin
            state_d     = IDLE;
            bit_cnt_d   = 3'd0;
            byte_d      = 2'd0;
            load_pend_d = 1'b0;
            cap_d       = 1'b0;
            miso_d      = 1'b0;
            oe_d        = 1'b0;
        end else begin
            if (cap_q) begin
                nxt_d       = bus.mem_rdata;
                load_pend_d = 1'b1;
                if (!oe_q) begin
                    sh_out_d = bus.mem_rdata;
                    miso_d   = bus.mem_rdata[7];
                    oe_d     = 1'b1;
                end
            end
            if (sclk_fall && (state_q == DATA || state_q == ID || state_q == STAT)) begin
                if (load_pend_q) begin
                    sh_out_d    = nxt_q;
                    miso_d      = nxt_q[7];
                    oe_d        = 1'b1;
                    load_pend_d = 1'b0;
                end else begin
                    sh_out_d = {sh_out_q[6:0], 1'b0};
                    miso_d   = sh_out_q[6];
                end
            end
            if (sclk_rise) begin
                sh_in_d   = rx;
                bit_cnt_d = bit_cnt_q + 3'd1;
                case (state_q)
                    CMD: if (last) begin
                        case (rx)
                            OP_READ:      begin state_d = ADDR; fast_d = 1'b0; end
                            OP_FAST_READ: begin state_d = ADDR; fast_d = 1'b1; end
                            OP_RDID: begin
                                state_d     = ID;
                                nxt_d       = id_byte(JEDEC_ID, 2'd0);
                                load_pend_d = 1'b1;
                                byte_d      = 2'd1;
                            end
                            OP_RDSR: begin
                                state_d     = STAT;
                                nxt_d       = STATUS;
                                load_pend_d = 1'b1;
                            end
                            default: begin state_d = IGNORE; cmd_err_d = 1'b1; end
                        endcase
                    end
                    ADDR: begin
                        addr_d = {addr_q[22:0], mosi_s};
                        if (last) begin
                            byte_d = byte_q + 2'd1;
                            if (byte_q == 2'd2) begin
                                byte_d     = 2'd0;
                                state_d    = fast_q ? DUMMY : DATA;
                                mem_req_d  = !fast_q;
                                mem_addr_d = fast_q ? mem_addr_q : {addr_q[22:0], mosi_s};
                            end
                        end
                    end
                    DUMMY: if (last) begin
                        state_d    = DATA;
                        mem_req_d  = 1'b1;
                        mem_addr_d = addr_q;
                    end
                    DATA: if (last) begin
                        addr_d     = addr_q + 24'd1;
                        mem_req_d  = 1'b1;
                        mem_addr_d = addr_q + 24'd1;
                    end
                    ID: if (last) begin
                        nxt_d       = id_byte(JEDEC_ID, byte_q);
                        load_pend_d = 1'b1;
                        byte_d      = byte_q == 2'd3 ? 2'd3 : byte_q + 2'd1;
                    end
                    STAT: if (last) begin
                        nxt_d       = STATUS;
                        load_pend_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (state_q == IDLE && cs_fall) begin
                state_d   = CMD;
                bit_cnt_d = 3'd0;
                byte_d    = 2'd0;
            end
        end
    end

    // State and output registers; every output is driven straight from a flop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            byte_q      <= 2'd0;
            addr_q      <= 24'd0;
            fast_q      <= 1'b0;
            sh_in_q     <= 8'd0;
            sh_out_q    <= 8'd0;
            nxt_q       <= 8'd0;
            load_pend_q <= 1'b0;
            cap_q       <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 24'd0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_q      <= byte_d;
            addr_q      <= addr_d;
            fast_q      <= fast_d;
            sh_in_q     <= sh_in_d;
            sh_out_q    <= sh_out_d;
            nxt_q       <= nxt_d;
            load_pend_q <= load_pend_d;
            cap_q       <= cap_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = oe_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign busy            = state_q != IDLE;
    assign cmd_err         = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: scoreboard bench driving the flash pins as a mode-0 fetch controller
module tb_spi_flash_responder;

    localparam int HALF = 80;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, cmd_err;

    spi_flash_responder_if bus();

    spi_flash_responder dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy(busy),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int req_cnt = 0;
    int err_cnt = 0;
    bit oe_seen = 1'b0;
    bit prev_req = 1'b0;
    logic [23:0] exp_addr[$];
    logic [7:0]  exp_byte[$];

    function automatic logic [7:0] model(input logic [23:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte store: data is valid exactly one clock after the request
    always @(posedge clk) bus.mem_rdata <= bus.mem_req ? model(bus.mem_addr) : 8'hEE;

    // Request monitor: pops the expected address for every strobe
    always @(negedge clk) begin
        if (bus.mem_req) begin
            req_cnt++;
            check("mem_req_width", 32'(prev_req), 32'd0);
            check("mem_req_expected", 32'(exp_addr.size() > 0), 32'd1);
            if (exp_addr.size() > 0) check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
        end
        prev_req = bus.mem_req;
        if (cmd_err) err_cnt++;
        if (bus.spi_miso_oe) oe_seen = 1'b1;
    end

    task automatic sclk_bit(input logic b, output logic r, input bit abort_cs);
        bus.spi_mosi = b;
        #HALF;
        bus.spi_sclk = 1'b1;
        if (abort_cs) bus.spi_cs_n = 1'b1;
        r = bus.spi_miso;
        #HALF;
        bus.spi_sclk = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, input bit abort_last);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            sclk_bit(tx[i], r, abort_last && i == 0);
            rx[i] = r;
        end
    endtask

    task automatic cs_start();
        bus.spi_cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_end();
        #HALF;
        bus.spi_cs_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] rx;
        xfer(op, rx, 1'b0);
        xfer(a[23:16], rx, 1'b0);
        xfer(a[15:8], rx, 1'b0);
        xfer(a[7:0], rx, 1'b0);
    endtask

    // READ of n bytes; CS rises together with the last SCLK rise so no prefetch follows
    task automatic do_read(input string tag, input logic [23:0] a, input int n);
        int r0;
        logic [7:0] rx;
        logic [23:0] ai;
        r0 = req_cnt;
        for (int i = 0; i < n; i++) begin
            ai = a + 24'(i);
            exp_addr.push_back(ai);
            exp_byte.push_back(model(ai));
        end
        cs_start();
        send_hdr(8'h03, a);
        check({tag, "_busy_active"}, 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, rx, i == n - 1);
            check({tag, "_byte"}, 32'(rx), 32'(exp_byte.pop_front()));
        end
        cs_end();
        check({tag, "_req_count"}, 32'(req_cnt - r0), 32'(n));
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int r0;
        int e0;
        logic r;
        logic [7:0] rx;
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(bus.spi_miso), 32'd0);
        check("rst_oe", 32'(bus.spi_miso_oe), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        rst_n = 1'b1;
        #(4 * HALF);

        do_read("read", 24'h000010, 2);
        do_read("wrap", 24'hFFFFFF, 2);

        r0 = req_cnt;
        exp_addr.push_back(24'h000100);
        exp_byte.push_back(model(24'h000100));
        cs_start();
        send_hdr(8'h0B, 24'h000100);
        check("fast_no_req_before_dummy", 32'(req_cnt - r0), 32'd0);
        xfer(8'hFF, rx, 1'b0);
        check("fast_req_after_dummy", 32'(req_cnt - r0), 32'd1);
        xfer(8'h00, rx, 1'b1);
        check("fast_byte", 32'(rx), 32'(exp_byte.pop_front()));
        cs_end();
        check("fast_req_count", 32'(req_cnt - r0), 32'd1);

        r0 = req_cnt;
        exp_byte.push_back(8'hEF);
        exp_byte.push_back(8'h40);
        exp_byte.push_back(8'h16);
        exp_byte.push_back(8'h00);
        cs_start();
        xfer(8'h9F, rx, 1'b0);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, rx, 1'b0);
            check("rdid_byte", 32'(rx), 32'(exp_byte.pop_front()));
        end
        cs_end();
        check("rdid_no_req", 32'(req_cnt - r0), 32'd0);

        r0 = req_cnt;
        e0 = err_cnt;
        oe_seen = 1'b0;
        cs_start();
        xfer(8'hAB, rx, 1'b0);
        xfer(8'h00, rx, 1'b0);
        cs_end();
        check("badop_cmd_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("badop_oe_quiet", 32'(oe_seen), 32'd0);
        check("badop_no_req", 32'(req_cnt - r0), 32'd0);

        r0 = req_cnt;
        cs_start();
        xfer(8'h03, rx, 1'b0);
        for (int i = 0; i < 12; i++) sclk_bit(1'b1, r, 1'b0);
        cs_end();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_req", 32'(req_cnt - r0), 32'd0);
        do_read("after_abort", 24'h000020, 1);

        exp_addr.push_back(24'h000030);
        cs_start();
        send_hdr(8'h03, 24'h000030);
        for (int i = 0; i < 4; i++) sclk_bit(1'b0, r, 1'b0);
        check("rstmid_oe_before", 32'(bus.spi_miso_oe), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rstmid_oe", 32'(bus.spi_miso_oe), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_miso", 32'(bus.spi_miso), 32'd0);
        rst_n = 1'b1;
        r0 = req_cnt;
        oe_seen = 1'b0;
        for (int i = 0; i < 12; i++) sclk_bit(1'b1, r, 1'b0);
        check("rstmid_ignored_oe", 32'(oe_seen), 32'd0);
        check("rstmid_ignored_busy", 32'(busy), 32'd0);
        check("rstmid_ignored_req", 32'(req_cnt - r0), 32'd0);
        cs_end();
        do_read("after_rst", 24'h000040, 1);

        check("leftover_addr", 32'(exp_addr.size()), 32'd0);
        check("leftover_byte", 32'(exp_byte.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
